// File: rtl/instr_fetch.sv
// Instruction fetch unit: sequences the program counter, reads a synchronous
// instruction memory and presents one instruction per cycle to the control
// unit. It supports stall, branch/jump redirect and a halt instruction.
module instr_fetch #(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [23:0]       NOP_CODE  = 24'h000000,
    parameter logic [23:0]       HALT_CODE = 24'hFFFFFF
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_en,
    input  logic [23:0]       imem_data,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [23:0]       code,
    output logic              code_valid,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted,
    output logic [15:0]       instr_count
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] pc_out_next;
    logic              code_valid_next;
    logic              consumed;

    // The memory output only carries a real instruction while code_valid is
    // set; otherwise the consumer sees a harmless NOP.
    assign code     = code_valid ? imem_data : NOP_CODE;
    assign halted   = (state == HALT);

    // An instruction is consumed when it is presented and either accepted or
    // overtaken by a redirect (a taken branch retires the stalled instruction).
    assign consumed = code_valid && (!stall || redirect);

    // Next-state and memory-port logic; redirect outranks stall and halt.
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        pc_out_next     = pc_out;
        code_valid_next = code_valid;
        imem_en         = 1'b0;
        imem_addr       = pc;
        case (state)
            BOOT: begin
                imem_en         = 1'b1;
                imem_addr       = RESET_PC;
                state_next      = RUN;
                pc_out_next     = RESET_PC;
                pc_next         = RESET_PC + PC_ONE;
                code_valid_next = 1'b1;
            end
            RUN: begin
                if (redirect) begin
                    imem_en         = 1'b1;
                    imem_addr       = redirect_pc;
                    pc_out_next     = redirect_pc;
                    pc_next         = redirect_pc + PC_ONE;
                    code_valid_next = 1'b1;
                end else if (stall) begin
                    imem_en = 1'b0;
                end else if (code_valid && (code == HALT_CODE)) begin
                    imem_en         = 1'b0;
                    state_next      = HALT;
                    code_valid_next = 1'b0;
                end else begin
                    imem_en         = 1'b1;
                    imem_addr       = pc;
                    pc_out_next     = pc;
                    pc_next         = pc + PC_ONE;
                    code_valid_next = 1'b1;
                end
            end
            HALT: begin
                code_valid_next = 1'b0;
                if (redirect) begin
                    imem_en         = 1'b1;
                    imem_addr       = redirect_pc;
                    state_next      = RUN;
                    pc_out_next     = redirect_pc;
                    pc_next         = redirect_pc + PC_ONE;
                    code_valid_next = 1'b1;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
        if (rst) begin
            imem_en   = 1'b0;
            imem_addr = RESET_PC;
        end
    end

    // State, program counter and presentation registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BOOT;
            pc         <= RESET_PC + PC_ONE;
            pc_out     <= RESET_PC;
            code_valid <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            pc_out     <= pc_out_next;
            code_valid <= code_valid_next;
        end
    end

    // Saturating count of consumed instructions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_count <= 16'd0;
        end else if (consumed && (instr_count != 16'hFFFF)) begin
            instr_count <= instr_count + 16'd1;
        end
    end

endmodule
